// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
package uart_pkg;

   localparam int NREQ_DEF    = 4;
   localparam int CMD_TMO_DEF = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2,
      ST_DONE   = 2'd3
   } tx_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index above last_grant, wrapping.
module rr_picker #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [2:0]      last_grant,
   output logic [2:0]      grant,
   output logic            found
);

   logic [7:0] elig_ext;
   logic [2:0] idx;

   assign elig_ext = 8'(eligible);

   // Walk the distances from farthest to nearest so the nearest eligible index wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = 3'((int'(last_grant) + k) % NREQ);
         if (elig_ext[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into a single UART transmitter.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int CMD_TMO = CMD_TMO_DEF
) (
   input  logic              bclk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_mask,
   output logic [NREQ-1:0]   req_ack,
   input  logic              tx_ready,
   output logic [7:0]        tx_din,
   output logic              tx_cmd,
   output logic              tx_done,
   output logic [2:0]        done_id,
   output logic              busy,
   output logic              tmo_err,
   output logic [15:0]       frame_cnt
);

   tx_state_e       state_q, state_d;
   logic [7:0]      tx_din_q, tx_din_d;
   logic [NREQ-1:0] req_ack_q, req_ack_d;
   logic [2:0]      last_grant_q, last_grant_d;
   logic [2:0]      done_id_q, done_id_d;
   logic            tmo_err_q, tmo_err_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic [7:0]      tmo_cnt_q, tmo_cnt_d;

   logic [2:0]      pick_grant;
   logic            pick_found;

   rr_picker #(
      .NREQ (NREQ)
   ) u_picker (
      .eligible   (req_valid & req_mask),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .found      (pick_found)
   );

   always_comb begin
      state_d      = state_q;
      tx_din_d     = tx_din_q;
      req_ack_d    = '0;
      last_grant_d = last_grant_q;
      done_id_d    = done_id_q;
      tmo_err_d    = tmo_err_q;
      frame_cnt_d  = frame_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_ready && pick_found) begin
               state_d      = ST_LAUNCH;
               last_grant_d = pick_grant;
               tmo_cnt_d    = '0;
               for (int i = 0; i < NREQ; i++) begin
                  if (3'(i) == pick_grant) begin
                     tx_din_d     = req_data[8*i +: 8];
                     req_ack_d[i] = 1'b1;
                  end
               end
            end
         end
         ST_LAUNCH: begin
            // Give up once the transmitter has ignored tx_cmd for CMD_TMO cycles.
            if (!tx_ready) begin
               state_d = ST_BUSY;
            end else if (tmo_cnt_q == 8'(CMD_TMO - 1)) begin
               state_d   = ST_IDLE;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         ST_BUSY: begin
            if (tx_ready) begin
               state_d     = ST_DONE;
               done_id_d   = last_grant_q;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tx_din_q     <= '0;
         req_ack_q    <= '0;
         last_grant_q <= 3'(NREQ - 1);
         done_id_q    <= '0;
         tmo_err_q    <= 1'b0;
         frame_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         tx_din_q     <= tx_din_d;
         req_ack_q    <= req_ack_d;
         last_grant_q <= last_grant_d;
         done_id_q    <= done_id_d;
         tmo_err_q    <= tmo_err_d;
         frame_cnt_q  <= frame_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign tx_din    = tx_din_q;
   assign req_ack   = req_ack_q;
   assign done_id   = done_id_q;
   assign tmo_err   = tmo_err_q;
   assign frame_cnt = frame_cnt_q;
   assign tx_cmd    = (state_q == ST_LAUNCH);
   assign tx_done   = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

endmodule
